// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the single-precision FP multiplier mantissa path.
package fp_mul_pkg;

  // Mantissa width including the hidden bit for binary32.
  localparam int MAN_W_SP = 24;

  // Radix-4 Booth digit selected by one overlapping bit triplet.
  typedef enum logic [2:0] {
    BD_ZERO = 3'd0,
    BD_P1   = 3'd1,
    BD_P2   = 3'd2,
    BD_M1   = 3'd3,
    BD_M2   = 3'd4
  } booth_dig_e;

  // Sequencer states of the iterative multiplier.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/fp_mul_booth_seq_enc.sv
// Radix-4 Booth encoder: decodes one bit triplet and produces the matching
// sign-extended partial product {0, +A, +2A, -A, -2A} of width MAN_W+3.
module booth_r4_enc
  import fp_mul_pkg::*;
#(
  parameter int MAN_W = MAN_W_SP
) (
  input  logic [2:0]       trip,
  input  logic [MAN_W-1:0] a,
  output logic [MAN_W+2:0] pp
);

  booth_dig_e       dig_s;
  logic [MAN_W+2:0] a1_s;
  logic [MAN_W+2:0] a2_s;

  // A and 2A zero-extended so that negation yields a correct signed value.
  assign a1_s = {3'b000, a};
  assign a2_s = {2'b00, a, 1'b0};

  // Map the triplet {b[2c+1], b[2c], b[2c-1]} to a Booth digit.
  always_comb begin
    dig_s = BD_ZERO;
    case (trip)
      3'b001, 3'b010: dig_s = BD_P1;
      3'b011:         dig_s = BD_P2;
      3'b100:         dig_s = BD_M2;
      3'b101, 3'b110: dig_s = BD_M1;
      default:        dig_s = BD_ZERO;
    endcase
  end

  // Select the partial product for the decoded digit.
  always_comb begin
    pp = {(MAN_W+3){1'b0}};
    case (dig_s)
      BD_P1:   pp = a1_s;
      BD_P2:   pp = a2_s;
      BD_M1:   pp = -a1_s;
      BD_M2:   pp = -a2_s;
      default: pp = {(MAN_W+3){1'b0}};
    endcase
  end

endmodule

// File: rtl/fp_mul_booth_seq.sv
// Iterative radix-4 Booth mantissa multiplier (one digit per cycle, LSB first).
// Optional macro BOOTH_EARLY_ZERO_EN: a flushed (zero/subnormal) operand skips
// the RUN phase and goes straight to DONE with a zero product.
module fp_mul_booth_seq
  import fp_mul_pkg::*;
#(
  parameter int MAN_W = MAN_W_SP,
  parameter int TAG_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAN_W-2:0]   frc_X,
  input  logic [MAN_W-2:0]   frc_Y,
  input  logic               Xsub,
  input  logic               Ysub,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*MAN_W-1:0] frc_Z_full,
  output logic               norm_n,
  output logic [TAG_W-1:0]   tag_out
);

  localparam int ITER = MAN_W/2 + 1;
  localparam int AW   = 2*MAN_W + 3;
  localparam int PPW  = MAN_W + 3;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]         state_r;
  logic [CW-1:0]      cnt_r;
  logic [AW-1:0]      acc_r;
  logic [PPW-1:0]     b_r;
  logic [MAN_W-1:0]   a_r;
  logic [TAG_W-1:0]   tag_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [2*MAN_W-1:0] frc_z_r;
  logic               norm_r;
  logic [TAG_W-1:0]   tag_out_r;

  logic [MAN_W-1:0]   opa_s;
  logic [MAN_W-1:0]   opb_s;
  logic               skip_s;
  logic [PPW-1:0]     pp_s;
  logic [AW-1:0]      acc_next_s;
  logic               last_s;

  // Flushed operands contribute a zero mantissa.
  assign opa_s = Xsub ? {MAN_W{1'b0}} : {1'b1, frc_X};
  assign opb_s = Ysub ? {MAN_W{1'b0}} : {1'b1, frc_Y};

`ifdef BOOTH_EARLY_ZERO_EN
  assign skip_s = Xsub | Ysub;
`else
  assign skip_s = 1'b0;
`endif

  booth_r4_enc #(.MAN_W(MAN_W)) u_enc (
    .trip (b_r[2:0]),
    .a    (a_r),
    .pp   (pp_s)
  );

  // Shift-add step: the partial product enters at the top of acc and the
  // accumulator drops two bits per digit. Doing the arithmetic shift before the
  // add keeps the sum inside AW bits; no set bits are ever shifted out because
  // each partial product lands at least 2*(digits remaining) bits above bit 0.
  assign acc_next_s = {{2{acc_r[AW-1]}}, acc_r[AW-1:2]} + {pp_s, {(AW-PPW){1'b0}}};
  assign last_s     = (cnt_r == CW'(ITER-1));

  // Sequencer, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      acc_r       <= {AW{1'b0}};
      b_r         <= {PPW{1'b0}};
      a_r         <= {MAN_W{1'b0}};
      tag_r       <= {TAG_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      frc_z_r     <= {(2*MAN_W){1'b0}};
      norm_r      <= 1'b0;
      tag_out_r   <= {TAG_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r        <= opa_s;
            b_r        <= {2'b00, opb_s, 1'b0};
            acc_r      <= {AW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            tag_r      <= tag_in;
            in_ready_r <= 1'b0;
            state_r    <= skip_s ? ST_DONE : ST_RUN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_RUN: begin
          acc_r <= acc_next_s;
          b_r   <= {2'b00, b_r[PPW-1:2]};
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (!out_valid_r) begin
            frc_z_r     <= acc_r[2*MAN_W-1:0];
            norm_r      <= acc_r[2*MAN_W-1];
            tag_out_r   <= tag_r;
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign frc_Z_full = frc_z_r;
  assign norm_n     = norm_r;
  assign tag_out    = tag_out_r;

endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// Directed self-checking bench for fp_mul_booth_seq (default MAN_W=24, TAG_W=12).
module tb_fp_mul_booth_seq;

`ifdef BOOTH_EARLY_ZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 14;
`endif
  localparam int LAT = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] frc_X;
  logic [22:0] frc_Y;
  logic        Xsub;
  logic        Ysub;
  logic [11:0] tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] frc_Z_full;
  logic        norm_n;
  logic [11:0] tag_out;

  int vectors = 0;
  int miscompares = 0;

  fp_mul_booth_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .frc_X      (frc_X),
    .frc_Y      (frc_Y),
    .Xsub       (Xsub),
    .Ysub       (Ysub),
    .tag_in     (tag_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frc_Z_full (frc_Z_full),
    .norm_n     (norm_n),
    .tag_out    (tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_op(input string name, input logic [22:0] fx, input logic [22:0] fy,
                       input logic xs, input logic ys, input logic [11:0] tg,
                       input logic [47:0] exp_p, input logic exp_n,
                       input int exp_lat, input int hold);
    int lat;
    lat = 0;
    while (!in_ready && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({name, "/in_ready_idle"}, 64'(in_ready), 64'd1);
    frc_X = fx; frc_Y = fy; Xsub = xs; Ysub = ys; tag_in = tg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; frc_X = 23'h0; frc_Y = 23'h0; Xsub = 1'b0; Ysub = 1'b0; tag_in = 12'h0;
    check({name, "/in_ready_busy"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({name, "/latency"}, 64'(lat), 64'(exp_lat));
    check({name, "/prod"}, 64'(frc_Z_full), 64'(exp_p));
    check({name, "/norm_n"}, 64'(norm_n), 64'(exp_n));
    check({name, "/tag"}, 64'(tag_out), 64'(tg));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, "/hold_valid"}, 64'(out_valid), 64'd1);
      check({name, "/hold_prod"}, 64'(frc_Z_full), 64'(exp_p));
      check({name, "/hold_tag"}, 64'(tag_out), 64'(tg));
      check({name, "/hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "/valid_drop"}, 64'(out_valid), 64'd0);
    check({name, "/back_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    frc_X = 23'h0; frc_Y = 23'h0; Xsub = 1'b0; Ysub = 1'b0; tag_in = 12'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/in_ready", 64'(in_ready), 64'd1);
    check("rst/out_valid", 64'(out_valid), 64'd0);
    check("rst/prod", 64'(frc_Z_full), 64'd0);
    check("rst/norm_n", 64'(norm_n), 64'd0);
    check("rst/tag", 64'(tag_out), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("1.5x1.5", 23'h400000, 23'h400000, 1'b0, 1'b0, 12'hA5C, 48'h9000_0000_0000, 1'b1, LAT, 0);
    do_op("1.0x1.0", 23'h000000, 23'h000000, 1'b0, 1'b0, 12'h123, 48'h4000_0000_0000, 1'b0, LAT, 0);
    do_op("maxxmax", 23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0, 12'hFFF, 48'hFFFF_FE00_0001, 1'b1, LAT, 0);
    do_op("xsub", 23'h123456, 23'h400000, 1'b1, 1'b0, 12'h3C3, 48'h0, 1'b0, ZLAT, 0);
    do_op("ysub", 23'h7FFFFF, 23'h0F0F0F, 1'b0, 1'b1, 12'h0A0, 48'h0, 1'b0, ZLAT, 0);
    do_op("1.0xmax", 23'h000000, 23'h7FFFFF, 1'b0, 1'b0, 12'h555, 48'h7FFF_FF80_0000, 1'b0, LAT, 0);
    do_op("1.25x1.75", 23'h200000, 23'h600000, 1'b0, 1'b0, 12'h801, 48'h8C00_0000_0000, 1'b1, LAT, 0);
    do_op("alt", 23'h2AAAAA, 23'h000001, 1'b0, 1'b0, 12'h7E7, 48'h5555_55AA_AAAA, 1'b0, LAT, 0);
    do_op("hold5", 23'h400000, 23'h200000, 1'b0, 1'b0, 12'hBEE, 48'h7800_0000_0000, 1'b0, LAT, 5);

    // Abort an operation mid-RUN with an asynchronous reset pulse.
    frc_X = 23'h400000; frc_Y = 23'h400000; tag_in = 12'h321; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort/out_valid", 64'(out_valid), 64'd0);
    check("abort/in_ready", 64'(in_ready), 64'd1);
    check("abort/prod", 64'(frc_Z_full), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      check("abort/no_partial", 64'(out_valid), 64'd0);
    end
    do_op("after_abort", 23'h400000, 23'h400000, 1'b0, 1'b0, 12'h456, 48'h9000_0000_0000, 1'b1, LAT, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
